tx_frame_unit: RTL and testbench
================================

TX_FRAME_UNIT -- requirements
Module: tx_frame_unit

Interface
REQ-001 SHALL have parameter DataLength, default 9, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter ClocksPerBit, default 16, Clock cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have port Clock  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Data  input  DataLength  parallel word to transmit.
REQ-006 SHALL have port Load  input  1  request to start a frame; sampled on rising Clock.
REQ-007 SHALL have port ParityEnable  input  1  1 = insert parity bit after data.
REQ-008 SHALL have port ParityOdd  input  1  1 = odd parity, 0 = even; ignored when ParityEnable=0.
REQ-009 SHALL have port TwoStop  input  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port Tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port Busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port Done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, Load=1 at a rising edge SHALL capture Data, ParityEnable, ParityOdd, TwoStop into internal registers and move to START; Busy=1 and Tx=0 from that edge.
REQ-015 Load while Busy=1 SHALL be ignored; input changes after capture SHALL not affect the frame in progress.
REQ-016 Each bit SHALL drive Tx for exactly ClocksPerBit cycles, timed by an internal bit-cycle counter cleared at each bit boundary.
REQ-017 START SHALL drive Tx=0 for one bit time, then go to DATA.
REQ-018 DATA SHALL shift captured bits LSB first, bit index counting 0..DataLength-1, then go to PARITY if captured ParityEnable=1, else STOP.
REQ-019 PARITY SHALL drive XOR of all captured data bits when ParityOdd=0, its inverse when ParityOdd=1.
REQ-020 STOP SHALL drive Tx=1 for one bit time (TwoStop=0) or two bit times (TwoStop=1), then return to IDLE.
REQ-021 On the edge entering IDLE from STOP, Busy SHALL go low and Done SHALL be high for exactly that one cycle.
REQ-022 Load=1 in the cycle Done=1 SHALL be accepted, giving back-to-back frames with no idle bit between stop and next start.
REQ-023 Frame length SHALL be (1+DataLength+ParityEnable+1+TwoStop)*ClocksPerBit cycles, Load edge to Done edge.
REQ-024 Counters SHALL be sized by $clog2 of their maximum and SHALL never wrap within a bit or frame.

Reset
REQ-025 Reset=1 SHALL immediately, without a Clock edge, force state IDLE, Tx=1, Busy=0, Done=0, counters and captured registers to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no Done pulse; first Load after Reset release SHALL start a fresh frame.
REQ-027 Load coincident with Reset SHALL be ignored.

Verification
REQ-028 Default params, ParityEnable=1, ParityOdd=0, TwoStop=0, Data=9'h155, Load pulse -> Tx 0,1,0,1,0,1,0,1,0,1, parity 1, stop 1; each bit 16 cycles; Done 192 cycles after Load edge.
REQ-029 Data=9'h1E2, ParityEnable=1, ParityOdd=1 -> data bits 0,1,0,0,0,1,1,1,1, parity bit 0 (five ones, odd parity).
REQ-030 DataLength=8, ClocksPerBit=4, ParityEnable=0, TwoStop=1, Data=8'hA5 -> 11-bit frame, 44 cycles, final 8 cycles Tx=1; Busy low and Done high on cycle 44.
REQ-031 Load re-asserted at cycle 50 of a frame with different Data -> ignored, frame bits unchanged; Load held through Done -> second start bit immediately follows stop bit.
REQ-032 Reset pulsed during DATA bit 4 -> Tx=1, Busy=0 asynchronously, no Done; next Load sends a complete correct frame.
REQ-033 Changing Data, ParityOdd, TwoStop after the Load edge -> transmitted frame matches the values captured at Load.

Source files
------------

// File: rtl/tx_frame_unit.sv
// tx_frame_unit: serial frame transmitter with start, data (LSB first), optional parity and one or two stop bits
module tx_frame_unit #(
  parameter int DataLength   = 9,
  parameter int ClocksPerBit = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DataLength-1:0] Data,
  input  logic                  Load,
  input  logic                  ParityEnable,
  input  logic                  ParityOdd,
  input  logic                  TwoStop,
  output logic                  Tx,
  output logic                  Busy,
  output logic                  Done
);
  localparam int CW = $clog2(ClocksPerBit);
  localparam int IW = $clog2(DataLength);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DataLength-1:0] data_q;
  logic                  pe_q;
  logic                  odd_q;
  logic                  two_q;
  logic                  bit_end;
  assign bit_end = cnt == CW'(ClocksPerBit - 1);
  // frame sequencer; idx counts data bits in DATA and stop bits in STOP
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      pe_q   <= 1'b0;
      odd_q  <= 1'b0;
      two_q  <= 1'b0;
      Tx     <= 1'b1;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      cnt  <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (Load) begin
          data_q <= Data;
          pe_q   <= ParityEnable;
          odd_q  <= ParityOdd;
          two_q  <= TwoStop;
          idx    <= '0;
          state  <= START;
          Busy   <= 1'b1;
          Tx     <= 1'b0;
        end
        START: if (bit_end) begin
          state <= DATA;
          idx   <= '0;
          Tx    <= data_q[0];
        end
        DATA: if (bit_end) begin
          if (idx == IW'(DataLength - 1)) begin
            state <= pe_q ? PARITY : STOP;
            Tx    <= pe_q ? (^data_q ^ odd_q) : 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
            Tx  <= data_q[idx + IW'(1)];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          Tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (idx == IW'(two_q)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else idx <= idx + IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tx_frame_unit.sv
// tb_tx_frame_unit: directed frame vectors against default and small-parameter instances
module tb_tx_frame_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, ld_a, ld_b, pe, odd, two;
  logic [8:0] data;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        sel;
    logic [8:0]  d;
    logic        p, o, t;
    logic [12:0] ev;
    int          n;
  } vec_t;
  vec_t vecs [6];
  tx_frame_unit dut_a (
    .Clock(clk), .Reset(rst), .Data(data), .Load(ld_a), .ParityEnable(pe),
    .ParityOdd(odd), .TwoStop(two), .Tx(tx_a), .Busy(busy_a), .Done(done_a)
  );
  tx_frame_unit #(.DataLength(8), .ClocksPerBit(4)) dut_b (
    .Clock(clk), .Reset(rst), .Data(data[7:0]), .Load(ld_b), .ParityEnable(pe),
    .ParityOdd(odd), .TwoStop(two), .Tx(tx_b), .Busy(busy_b), .Done(done_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic frame(input logic sel, input logic [8:0] d, input logic p, input logic o,
                       input logic t, input logic [12:0] ev, input int n, input int mode);
    int cpb;
    cpb  = sel ? 4 : 16;
    data = d;
    pe   = p;
    odd  = o;
    two  = t;
    if (sel) ld_b = 1'b1;
    else ld_a = 1'b1;
    @(posedge clk);
    #1;
    ld_a = 1'b0;
    ld_b = 1'b0;
    for (int c = 0; c < n * cpb; c++) begin
      if (mode == 2 && c == 1) begin
        data = ~d;
        pe   = ~p;
        odd  = ~o;
        two  = ~t;
      end
      if (mode == 1 && c == 50) begin
        ld_a = 1'b1;
        data = ~d;
      end
      chk("tx_bit", sel ? tx_b : tx_a, ev[c / cpb]);
      chk("busy_frame", sel ? busy_b : busy_a, 1);
      chk("done_frame", sel ? done_b : done_a, 0);
      @(posedge clk);
      #1;
    end
    chk("done_end", sel ? done_b : done_a, 1);
    chk("busy_end", sel ? busy_b : busy_a, 0);
    chk("tx_end", sel ? tx_b : tx_a, 1);
    if (mode == 1) begin
      @(posedge clk);
      #1;
      chk("b2b_start_tx", tx_a, 0);
      chk("b2b_busy", busy_a, 1);
      chk("b2b_done_low", done_a, 0);
      ld_a = 1'b0;
    end
  endtask
  initial begin
    vecs[0] = '{1'b0, 9'h155, 1'b1, 1'b0, 1'b0, 13'h0EAA, 12};
    vecs[1] = '{1'b0, 9'h1E2, 1'b1, 1'b1, 1'b0, 13'h0BC4, 12};
    vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 13'h0C00, 12};
    vecs[3] = '{1'b0, 9'h1FF, 1'b1, 1'b0, 1'b1, 13'h1FFE, 13};
    vecs[4] = '{1'b0, 9'h0F0, 1'b1, 1'b1, 1'b0, 13'h0DE0, 12};
    vecs[5] = '{1'b1, 9'h0A5, 1'b0, 1'b0, 1'b1, 13'h074A, 11};
    rst  = 1'b0;
    ld_a = 1'b0;
    ld_b = 1'b0;
    pe   = 1'b0;
    odd  = 1'b0;
    two  = 1'b0;
    data = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_tx", tx_a, 1);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_tx_b", tx_b, 1);
    ld_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("load_in_reset_busy", busy_a, 0);
    chk("load_in_reset_tx", tx_a, 1);
    ld_a = 1'b0;
    rst  = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", busy_a, 0);
    for (int i = 0; i < 6; i++)
      frame(vecs[i].sel, vecs[i].d, vecs[i].p, vecs[i].o, vecs[i].t, vecs[i].ev, vecs[i].n, 0);
    repeat (3) @(posedge clk);
    #1;
    frame(1'b0, 9'h1E2, 1'b1, 1'b1, 1'b0, 13'h0BC4, 12, 2);
    repeat (2) @(posedge clk);
    #1;
    frame(1'b0, 9'h155, 1'b1, 1'b0, 1'b0, 13'h0EAA, 12, 1);
    repeat (85) @(posedge clk);
    #2;
    chk("bit4_tx_before_reset", tx_a, 0);
    chk("bit4_busy_before_reset", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("abort_tx", tx_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_abort", done_a, 0);
    end
    frame(1'b0, 9'h155, 1'b1, 1'b0, 1'b0, 13'h0EAA, 12, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
